branch_resolution_queue: RTL and testbench

In-order queue of branch predictions between fetch and execute. The branch predictor's output is recorded per control-flow instruction at fetch. When execute resolves that instruction, the queue compares the actual outcome with the recorded prediction. It then issues a registered pipeline redirect on mispredict and a registered training update back to the predictor for every resolved branch.

---
 rtl/branch_resolution_queue.sv | 126 ++++++++++++
 tb/tb_branch_resolution_queue.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolution_queue.sv
// In-order queue of branch predictions between fetch and execute. Pops the oldest
// prediction on resolve, emits a registered training update and, on mispredict, a flush.
module branch_resolution_queue #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic                           pred_valid,
  input  logic [WORD_W-1:0]              pred_pc,
  input  logic                           pred_taken,
  input  logic [WORD_W-1:0]              pred_target,
  output logic                           pred_ready,
  input  logic                           res_valid,
  input  logic [WORD_W-1:0]              res_pc,
  input  logic                           res_taken,
  input  logic [WORD_W-1:0]              res_target,
  output logic                           flush_req,
  output logic [WORD_W-1:0]              flush_pc,
  output logic                           upd_valid,
  output logic [WORD_W-1:0]              upd_pc,
  output logic [WORD_W-1:0]              upd_target,
  output logic                           upd_taken,
  output logic                           upd_mispredict,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy,
  output logic                           err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  function automatic logic [WORD_W-1:0] redirect_pc(input logic taken,
                                                    input logic [WORD_W-1:0] target,
                                                    input logic [WORD_W-1:0] pc);
    return taken ? target : pc + WORD_W'(4);
  endfunction

  logic [WORD_W-1:0] pc_mem     [DEPTH];
  logic [WORD_W-1:0] target_mem [DEPTH];
  logic [DEPTH-1:0]  taken_mem;

  logic [PTR_W-1:0]  wptr, rptr;
  logic [CNT_W-1:0]  cnt;
  logic              err_q;

  logic              full, empty;
  logic [WORD_W-1:0] head_pc, head_target;
  logic              head_taken;
  logic              res_fire, pc_bad, mispredict, flush, enq;

  logic              upd_valid_p1, upd_taken_p1, upd_mispredict_p1, flush_req_p1;
  logic [WORD_W-1:0] upd_pc_p1, upd_target_p1, flush_pc_p1;

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);

  // Ready depends only on held state, never on this cycle's resolve.
  assign pred_ready = !nRST && !full;

  assign head_pc     = pc_mem[rptr];
  assign head_target = target_mem[rptr];
  assign head_taken  = taken_mem[rptr];

  assign res_fire   = res_valid && !empty;
  assign pc_bad     = (res_pc != head_pc);
  assign mispredict = pc_bad || (head_taken != res_taken) ||
                      (res_taken && (head_target != res_target));
  assign flush      = res_fire && mispredict;
  // A flush squashes everything younger, including a same-cycle enqueue.
  assign enq        = pred_valid && pred_ready && !flush;

  always_ff @(posedge CLK) begin
    if (enq) begin
      pc_mem[wptr]     <= pred_pc;
      target_mem[wptr] <= pred_target;
      taken_mem[wptr]  <= pred_taken;
    end
  end

  // Stage p0 -> p1: queue state update and registered resolve outputs.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      wptr              <= '0;
      rptr              <= '0;
      cnt               <= '0;
      err_q             <= 1'b0;
      upd_valid_p1      <= 1'b0;
      upd_pc_p1         <= '0;
      upd_taken_p1      <= 1'b0;
      upd_target_p1     <= '0;
      upd_mispredict_p1 <= 1'b0;
      flush_req_p1      <= 1'b0;
      flush_pc_p1       <= '0;
    end else begin
      if (flush) begin
        cnt  <= '0;
        rptr <= wptr;
      end else begin
        if (enq)      wptr <= wptr + PTR_W'(1);
        if (res_fire) rptr <= rptr + PTR_W'(1);
        cnt <= cnt + CNT_W'(enq) - CNT_W'(res_fire);
      end
      err_q        <= err_q || (res_valid && empty) || (res_fire && pc_bad);
      upd_valid_p1 <= res_fire;
      flush_req_p1 <= flush;
      if (res_fire) begin
        upd_pc_p1         <= head_pc;
        upd_taken_p1      <= res_taken;
        upd_target_p1     <= res_target;
        upd_mispredict_p1 <= mispredict;
      end
      if (flush) flush_pc_p1 <= redirect_pc(res_taken, res_target, head_pc);
    end
  end

  assign upd_valid      = upd_valid_p1;
  assign upd_pc         = upd_pc_p1;
  assign upd_taken      = upd_taken_p1;
  assign upd_target     = upd_target_p1;
  assign upd_mispredict = upd_mispredict_p1;
  assign flush_req      = flush_req_p1;
  assign flush_pc       = flush_pc_p1;
  assign occupancy      = cnt;
  assign err            = err_q;

endmodule

// File: tb/tb_branch_resolution_queue.sv
// Directed bench for branch_resolution_queue: a queue model predicts each update/flush
// pulse, a negedge monitor pops and compares it in the cycle it is due.
module tb_branch_resolution_queue;
  localparam int DEPTH  = 4;
  localparam int WORD_W = 32;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              pred_valid, pred_taken, res_valid, res_taken;
  logic [WORD_W-1:0] pred_pc, pred_target, res_pc, res_target;
  logic              pred_ready, flush_req, upd_valid, upd_taken, upd_mispredict, err;
  logic [WORD_W-1:0] flush_pc, upd_pc, upd_target;
  logic [2:0]        occupancy;

  branch_resolution_queue #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken), .res_target(res_target),
    .flush_req(flush_req), .flush_pc(flush_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .occupancy(occupancy), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [WORD_W-1:0] pc;
    logic              tk;
    logic [WORD_W-1:0] tg;
  } ent_t;

  typedef struct {
    int                due;
    logic [WORD_W-1:0] pc;
    logic              tk;
    logic [WORD_W-1:0] tg;
    logic              mis;
    logic [WORD_W-1:0] fpc;
  } exp_t;

  ent_t mq[$];
  exp_t sbq[$];
  logic merr = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      exp_t e;
      bit due_now;
      due_now = (sbq.size() > 0) && (sbq[0].due == cyc);
      chk("upd_valid", {63'd0, upd_valid}, {63'd0, due_now});
      if (due_now) begin
        e = sbq.pop_front();
        chk("upd_pc", {32'd0, upd_pc}, {32'd0, e.pc});
        chk("upd_taken", {63'd0, upd_taken}, {63'd0, e.tk});
        chk("upd_target", {32'd0, upd_target}, {32'd0, e.tg});
        chk("upd_mispredict", {63'd0, upd_mispredict}, {63'd0, e.mis});
        chk("flush_req", {63'd0, flush_req}, {63'd0, e.mis});
        if (e.mis) chk("flush_pc", {32'd0, flush_pc}, {32'd0, e.fpc});
      end else begin
        chk("flush_idle", {63'd0, flush_req}, 64'd0);
      end
    end
  end

  // One clock of stimulus; the model decides what the DUT should do with it.
  task automatic step(input logic pv, input logic [WORD_W-1:0] ppc, input logic ptk,
                      input logic [WORD_W-1:0] ptg, input logic rv,
                      input logic [WORD_W-1:0] rpc, input logic rtk,
                      input logic [WORD_W-1:0] rtg);
    int   sz;
    bit   rdy, mis, bad;
    ent_t h, n;
    exp_t e;
    pred_valid = pv; pred_pc = ppc; pred_taken = ptk; pred_target = ptg;
    res_valid = rv; res_pc = rpc; res_taken = rtk; res_target = rtg;
    sz  = mq.size();
    rdy = (sz != DEPTH);
    mis = 1'b0;
    if (rv) begin
      if (sz == 0) merr = 1'b1;
      else begin
        h   = mq[0];
        bad = (rpc != h.pc);
        if (bad) merr = 1'b1;
        mis = bad || (h.tk != rtk) || (rtk && (h.tg != rtg));
        e.due = cyc + 1; e.pc = h.pc; e.tk = rtk; e.tg = rtg; e.mis = mis;
        e.fpc = rtk ? rtg : h.pc + 32'd4;
        sbq.push_back(e);
        if (mis) mq.delete();
        else void'(mq.pop_front());
      end
    end
    if (pv && rdy && !mis) begin
      n.pc = ppc; n.tk = ptk; n.tg = ptg;
      mq.push_back(n);
    end
    @(posedge CLK);
    #1;
    chk("occupancy", {61'd0, occupancy}, 64'(mq.size()));
    chk("pred_ready", {63'd0, pred_ready}, {63'd0, (mq.size() != DEPTH)});
    chk("err", {63'd0, err}, {63'd0, merr});
  endtask

  task automatic enq(input logic [WORD_W-1:0] pc, input logic tk, input logic [WORD_W-1:0] tg);
    step(1'b1, pc, tk, tg, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic res(input logic [WORD_W-1:0] pc, input logic tk, input logic [WORD_W-1:0] tg);
    step(1'b0, '0, 1'b0, '0, 1'b1, pc, tk, tg);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  // Reset with both request inputs active; every output must read zero.
  task automatic do_reset(input int n);
    nRST = 1'b1;
    pred_valid = 1'b1; pred_pc = 32'h100; pred_taken = 1'b1; pred_target = 32'h80;
    res_valid = 1'b1; res_pc = 32'h100; res_taken = 1'b0; res_target = 32'h44;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      chk("rst_pred_ready", {63'd0, pred_ready}, 64'd0);
      chk("rst_occupancy", {61'd0, occupancy}, 64'd0);
      chk("rst_err", {63'd0, err}, 64'd0);
      chk("rst_upd_valid", {63'd0, upd_valid}, 64'd0);
      chk("rst_flush_req", {63'd0, flush_req}, 64'd0);
      chk("rst_outs", {upd_pc, flush_pc}, 64'd0);
      chk("rst_upd_misc", {upd_target, 30'd0, upd_taken, upd_mispredict}, 64'd0);
      mon_en = 1'b1;
    end
    mq.delete();
    merr = 1'b0;
    nRST = 1'b0; pred_valid = 1'b0; res_valid = 1'b0;
    #1;
    chk("rel_pred_ready", {63'd0, pred_ready}, 64'd1);
    chk("rel_occupancy", {61'd0, occupancy}, 64'd0);
  endtask

  initial begin
    logic [WORD_W-1:0] base;
    do_reset(2);

    // Correct prediction.
    enq(32'h100, 1'b1, 32'h80);
    res(32'h100, 1'b1, 32'h80);
    idle();

    // Direction mispredict; the enqueue alongside the resolve is squashed.
    enq(32'h200, 1'b0, 32'h0);
    enq(32'h210, 1'b0, 32'h0);
    enq(32'h220, 1'b0, 32'h0);
    step(1'b1, 32'h230, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h400);
    idle();
    idle();

    // Target mispredict, then not-taken redirect wrapping past the top of memory.
    enq(32'h500, 1'b1, 32'h300);
    res(32'h500, 1'b1, 32'h340);
    enq(32'hFFFF_FFFC, 1'b1, 32'h10);
    res(32'hFFFF_FFFC, 1'b0, 32'h0);
    idle();

    // Fill, resolve while full with a dropped enqueue, refill, drain; three times.
    for (int r = 0; r < 3; r++) begin
      base = 32'h1000 + 32'(r) * 32'h100;
      for (int i = 0; i < DEPTH; i++)
        enq(base + 32'(4 * i), i[0], base + 32'h80 + 32'(i));
      step(1'b1, base + 32'h40, 1'b0, 32'h0, 1'b1, base, 1'b0, 32'h0);
      enq(base + 32'h50, 1'b1, base + 32'h90);
      res(base + 32'h4, 1'b1, base + 32'h81);
      res(base + 32'h8, 1'b0, 32'h0);
      res(base + 32'hC, 1'b1, base + 32'h83);
      res(base + 32'h50, 1'b1, base + 32'h90);
      idle();
    end

    // Resolve with nothing outstanding; err is sticky.
    res(32'h999, 1'b1, 32'h44);
    idle();
    idle();
    idle();

    // PC mismatch forces a flush and sets err.
    do_reset(1);
    enq(32'h100, 1'b1, 32'h80);
    res(32'h104, 1'b1, 32'h80);
    idle();
    idle();

    // Reset in the middle of traffic, with a resolve pending on the reset edge.
    enq(32'h700, 1'b0, 32'h0);
    enq(32'h710, 1'b1, 32'h7A0);
    do_reset(1);
    idle();
    enq(32'h720, 1'b1, 32'h7C0);
    res(32'h720, 1'b1, 32'h7C0);
    idle();
    idle();

    mon_en = 1'b0;
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
